// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared arbiter state and memory request types
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - unified memory port arbiter for fetch and load/store
module imem_dmem_arbiter
    import rv32i_types::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    arb_state_t    state_q, state_d;
    mem_req_t      req_q, req_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          squash_q, squash_d;

    logic i_valid;
    logic d_valid;

    assign i_valid = |imem_rmask;
    assign d_valid = |(dmem_rmask | dmem_wmask);

    // Memory port comes straight from the request register; it is zeroed
    // whenever the arbiter returns to IDLE, so the port is quiet between grants.
    assign mem_addr  = req_q.addr;
    assign mem_rmask = req_q.rmask;
    assign mem_wmask = req_q.wmask;
    assign mem_wdata = req_q.wdata;

    // State and request registers, abandoned immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            req_q    <= '0;
            starve_q <= '0;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            starve_q <= starve_d;
            squash_q <= squash_d;
        end
    end

    // Grant selection and transaction completion
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        starve_d = starve_q;
        squash_d = squash_q;
        case (state_q)
            IDLE: begin
                // Data wins unless fetch has waited out its starvation budget.
                // A flushed fetch is not a real contender this cycle.
                if (d_valid && (!i_valid || flush || (starve_q < LIMIT))) begin
                    state_d     = D_BUSY;
                    req_d.addr  = dmem_addr;
                    req_d.rmask = dmem_rmask;
                    req_d.wmask = dmem_wmask;
                    req_d.wdata = dmem_wdata;
                    if (i_valid && !flush && (starve_q != LIMIT)) begin
                        starve_d = starve_q + CW'(1);
                    end
                end else if (i_valid && !flush) begin
                    state_d     = I_BUSY;
                    req_d.addr  = imem_addr;
                    req_d.rmask = imem_rmask;
                    req_d.wmask = 4'h0;
                    req_d.wdata = 32'h0;
                    starve_d    = '0;
                    squash_d    = 1'b0;
                end
            end
            I_BUSY: begin
                // A redirect at any point poisons this fetch's response.
                if (flush) begin
                    squash_d = 1'b1;
                end
                if (mem_resp) begin
                    state_d = IDLE;
                    req_d   = '0;
                end
            end
            D_BUSY: begin
                // Loads and stores always finish; flush is ignored here.
                if (mem_resp) begin
                    state_d = IDLE;
                    req_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = '0;
            end
        endcase
    end

    // Route the memory completion to its owner in the same cycle
    always_comb begin
        imem_resp  = 1'b0;
        imem_rdata = 32'h0;
        dmem_resp  = 1'b0;
        dmem_rdata = 32'h0;
        case (state_q)
            I_BUSY: begin
                imem_resp  = mem_resp & ~squash_q & ~flush;
                imem_rdata = imem_resp ? mem_rdata : 32'h0;
            end
            D_BUSY: begin
                dmem_resp  = mem_resp;
                dmem_rdata = mem_resp ? mem_rdata : 32'h0;
            end
            default: begin
                imem_resp = 1'b0;
                dmem_resp = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb/tb_imem_dmem_arbiter.sv - directed self-checking bench for imem_dmem_arbiter
module tb_imem_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    int n_checks = 0;
    int n_errors = 0;

    imem_dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .mem_addr   (mem_addr),
        .mem_rmask  (mem_rmask),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resp_on(input logic [31:0] d);
        mem_resp  = 1'b1;
        mem_rdata = d;
        #1;
    endtask

    task automatic resp_off();
        mem_resp  = 1'b0;
        mem_rdata = 32'h0;
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        imem_addr  = 32'h0;
        imem_rmask = 4'h0;
        dmem_addr  = 32'h0;
        dmem_rmask = 4'h0;
        dmem_wmask = 4'h0;
        dmem_wdata = 32'h0;
        mem_rdata  = 32'h0;
        mem_resp   = 1'b0;
        tick();
        tick();

        // reset state
        check("rst_mem_addr",  mem_addr,  32'h0);
        check("rst_mem_rmask", mem_rmask, 32'h0);
        check("rst_mem_wmask", mem_wmask, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_imem_resp", imem_resp, 32'h0);
        check("rst_dmem_resp", dmem_resp, 32'h0);
        check("rst_imem_rdata", imem_rdata, 32'h0);
        check("rst_dmem_rdata", dmem_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // fetch only, memory answers on the third request cycle
        imem_addr  = 32'h6000_0000;
        imem_rmask = 4'hF;
        tick();
        check("f_mem_addr",  mem_addr,  32'h6000_0000);
        check("f_mem_rmask", mem_rmask, 32'hF);
        check("f_mem_wmask", mem_wmask, 32'h0);
        check("f_no_resp",   imem_resp, 32'h0);
        tick();
        check("f_hold_addr",  mem_addr,  32'h6000_0000);
        check("f_hold_wmask", mem_wmask, 32'h0);
        tick();
        resp_on(32'h0000_0013);
        check("f_imem_resp",  imem_resp,  32'h1);
        check("f_imem_rdata", imem_rdata, 32'h0000_0013);
        check("f_dmem_resp",  dmem_resp,  32'h0);
        check("f_resp_wmask", mem_wmask,  32'h0);
        imem_rmask = 4'h0;
        tick();
        resp_off();
        check("f_idle_addr",  mem_addr,   32'h0);
        check("f_idle_rdata", imem_rdata, 32'h0);

        // simultaneous fetch and load: data first, then fetch after an IDLE cycle
        imem_addr  = 32'h6000_0004;
        imem_rmask = 4'hF;
        dmem_addr  = 32'h0000_1000;
        dmem_rmask = 4'hF;
        tick();
        check("s_d_addr",  mem_addr,  32'h0000_1000);
        check("s_d_rmask", mem_rmask, 32'hF);
        resp_on(32'hCAFE_0001);
        check("s_dmem_resp",  dmem_resp,  32'h1);
        check("s_dmem_rdata", dmem_rdata, 32'hCAFE_0001);
        check("s_imem_resp",  imem_resp,  32'h0);
        dmem_rmask = 4'h0;
        tick();
        resp_off();
        check("s_idle_addr", mem_addr, 32'h0);
        tick();
        check("s_i_addr", mem_addr, 32'h6000_0004);
        resp_on(32'h0000_0011);
        check("s_imem_resp", imem_resp, 32'h1);
        imem_rmask = 4'h0;
        tick();
        resp_off();

        // starvation: four data grants then fetch is forced through
        imem_addr  = 32'h6000_0008;
        imem_rmask = 4'hF;
        dmem_addr  = 32'h0000_3000;
        dmem_rmask = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("st_grant%0d", k), mem_addr, (k < 4) ? 32'h0000_3000 : 32'h6000_0008);
            resp_on(32'h0000_0100 + k);
            if (k == 4) imem_rmask = 4'h0;
            tick();
            resp_off();
        end
        // counter was cleared by the fetch grant, so data wins again
        imem_addr  = 32'h6000_000C;
        imem_rmask = 4'hF;
        tick();
        check("st_reset_d", mem_addr, 32'h0000_3000);
        resp_on(32'h0);
        imem_rmask = 4'h0;
        dmem_rmask = 4'h0;
        tick();
        resp_off();
        tick();

        // fetch is never granted while flush is high
        imem_addr  = 32'h6000_0010;
        imem_rmask = 4'hF;
        flush      = 1'b1;
        tick();
        check("fl_no_grant", mem_addr, 32'h0);
        flush = 1'b0;
        tick();
        check("fl_i_addr", mem_addr, 32'h6000_0010);
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        imem_addr = 32'h6000_0100;
        check("fl_hold_addr", mem_addr, 32'h6000_0010);
        resp_on(32'h0000_0099);
        check("fl_squash_resp",  imem_resp,  32'h0);
        check("fl_squash_rdata", imem_rdata, 32'h0);
        tick();
        resp_off();
        check("fl_idle_addr", mem_addr, 32'h0);
        tick();
        check("fl_redir_addr", mem_addr, 32'h6000_0100);
        resp_on(32'h0000_0077);
        check("fl_redir_resp",  imem_resp,  32'h1);
        check("fl_redir_rdata", imem_rdata, 32'h0000_0077);
        imem_rmask = 4'h0;
        tick();
        resp_off();

        // flush in the same cycle as the response also drops it
        imem_addr  = 32'h6000_0200;
        imem_rmask = 4'hF;
        tick();
        flush = 1'b1;
        resp_on(32'h0000_0055);
        check("fl_same_cycle", imem_resp, 32'h0);
        imem_rmask = 4'h0;
        tick();
        flush = 1'b0;
        resp_off();

        // store survives a flush
        dmem_addr  = 32'h0000_2000;
        dmem_wmask = 4'hF;
        dmem_wdata = 32'hDEAD_BEEF;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("sw_addr",  mem_addr,  32'h0000_2000);
        check("sw_wmask", mem_wmask, 32'hF);
        check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("sw_rmask", mem_rmask, 32'h0);
        resp_on(32'h0);
        check("sw_dmem_resp", dmem_resp, 32'h1);
        dmem_wmask = 4'h0;
        tick();
        resp_off();
        check("sw_idle_wmask", mem_wmask, 32'h0);

        // async reset mid-fetch
        imem_addr  = 32'h6000_0020;
        imem_rmask = 4'hF;
        tick();
        check("ar_i_addr", mem_addr, 32'h6000_0020);
        #2;
        rst = 1'b1;
        #1;
        check("ar_mem_addr",  mem_addr,  32'h0);
        check("ar_mem_rmask", mem_rmask, 32'h0);
        imem_rmask = 4'h0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        resp_on(32'h0000_0AAA);
        check("ar_imem_resp", imem_resp, 32'h0);
        check("ar_dmem_resp", dmem_resp, 32'h0);
        tick();
        resp_off();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
